// File: rtl/square_pkg.sv
// Shared definitions for the serial squarer: default root width, square-width rule, FSM states.
package square_pkg;

    localparam int ROOT_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int sq_w(input int root_w);
        return 2 * root_w;
    endfunction

endpackage

// File: rtl/square_from_root.sv
// Serial shift-add squarer that consumes one root bit per CALC cycle.
// Define SQUARE_HI_EN to add square_hi, the largest num whose floor square root is root.
//   state | meaning
//   IDLE  | waiting for start, last result held
//   CALC  | one multiplier bit added per edge
//   DONE  | result valid, one-cycle done pulse
module square_from_root
    import square_pkg::*;
#(
    parameter int ROOT_W = ROOT_W_DEF,
    localparam int SQ_W = sq_w(ROOT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROOT_W-1:0] root,
    output logic              busy,
    output logic              done,
    output logic [SQ_W-1:0]   square
`ifdef SQUARE_HI_EN
    ,
    output logic [SQ_W-1:0]   square_hi
`endif
);
    localparam int CNT_W = $clog2(ROOT_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROOT_W - 1);

    state_t            state_q, state_d;
    logic [SQ_W-1:0]   mcand_q, mcand_d;
    logic [ROOT_W-1:0] mplier_q, mplier_d;
    logic [SQ_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SQ_W-1:0]   square_q, square_d;
    logic [SQ_W-1:0]   sum;
    logic              last;

    assign last = (cnt_q == LAST_CNT);
    assign sum  = acc_q + (mplier_q[0] ? (mcand_q << cnt_q) : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == DONE);
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        square_d = square_q;
        if (state_q == IDLE && start) begin
            mcand_d  = {{(SQ_W - ROOT_W){1'b0}}, root};
            mplier_d = root;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == CALC) begin
            acc_d    = sum;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last) square_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            square_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            square_q <= square_d;
        end
    end

    assign square = square_q;

`ifdef SQUARE_HI_EN
    // root^2 + 2*root peaks at 2^SQ_W - 1, so no carry out is possible.
    logic [SQ_W-1:0] square_hi_q, square_hi_d;

    always_comb begin
        square_hi_d = square_hi_q;
        if (state_q == CALC && last) square_hi_d = sum + (mcand_q << 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            square_hi_q <= '0;
        end else begin
            square_hi_q <= square_hi_d;
        end
    end

    assign square_hi = square_hi_q;
`endif

endmodule

// File: tb/tb_square_from_root.sv
// Scoreboard bench for square_from_root: stimulus pushes expected results, a monitor pops on done.
module tb_square_from_root;

    localparam int RW = 5;
    localparam int SW = 2 * RW;

    typedef struct {
        int sq;
        int hi;
        int dcyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [RW-1:0] root;
    logic          busy;
    logic          done;
    logic [SW-1:0] square;
`ifdef SQUARE_HI_EN
    logic [SW-1:0] square_hi;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    square_from_root #(.ROOT_W(RW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .root   (root),
        .busy   (busy),
        .done   (done),
        .square (square)
`ifdef SQUARE_HI_EN
        ,
        .square_hi (square_hi)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog no completion by time %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    function automatic exp_t model(input int r, input int e0);
        exp_t e;
        e.sq   = r * r;
        e.hi   = r * r + 2 * r;
        e.dcyc = e0 + RW;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                chk("done_expected", (q.size() > 0) ? 1 : 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("square", int'(square), e.sq);
                    chk("done_cycle", cyc, e.dcyc);
`ifdef SQUARE_HI_EN
                    chk("square_hi", int'(square_hi), e.hi);
`endif
                end
            end
        end
    end

    task automatic run_op(input int r);
        int held;
        @(negedge clk);
        held  = int'(square);
        root  = RW'(r);
        start = 1'b1;
        q.push_back(model(r, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        root  = RW'($urandom_range(0, 31));
        for (int k = 0; k < RW; k++) begin
            chk("busy_calc", int'(busy), 1);
            chk("square_hold", int'(square), held);
            @(negedge clk);
        end
        chk("busy_done", int'(busy), 0);
        @(negedge clk);
        chk("busy_idle", int'(busy), 0);
        chk("done_idle", int'(done), 0);
    endtask

    initial begin
        int e0;
        rst   = 1'b1;
        start = 1'b0;
        root  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_square", int'(square), 0);
`ifdef SQUARE_HI_EN
        chk("rst_square_hi", int'(square_hi), 0);
`endif
        // start during reset must be overridden
        start = 1'b1;
        root  = RW'(17);
        @(negedge clk);
        chk("rst_over_start", int'(busy), 0);
        start = 1'b0;
        rst   = 1'b0;

        run_op(12);
        run_op(31);
        run_op(0);

        // second start during CALC is ignored
        @(negedge clk);
        root  = RW'(5);
        start = 1'b1;
        q.push_back(model(5, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        root  = RW'(9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignored_start", int'(busy), 1);
        repeat (RW + 6) @(negedge clk);
        chk("square_after_ignore", int'(square), 25);
        chk("queue_after_ignore", q.size(), 0);

        // reset aborts a running operation
        @(negedge clk);
        root  = RW'(20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_square", int'(square), 0);
        rst = 1'b0;
        repeat (RW + 3) @(negedge clk);
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_square_idle", int'(square), 0);
        run_op(3);

        // back-to-back: start held high, next accept one edge after DONE
        @(negedge clk);
        root  = RW'(7);
        start = 1'b1;
        e0    = cyc + 1;
        q.push_back(model(7, e0));
        @(negedge clk);
        root = RW'(10);
        q.push_back(model(10, e0 + RW + 2));
        while (cyc < e0 + 2 * RW + 3) begin
            if (cyc == e0 + RW + 1) chk("b2b_idle_gap", int'(busy), 0);
            if (cyc == e0 + RW + 2) begin
                chk("b2b_second_accept", int'(busy), 1);
                start = 1'b0;
            end
            if (cyc >= e0 + RW && cyc < e0 + 2 * RW + 2) chk("b2b_square_held", int'(square), 49);
            @(negedge clk);
        end

        for (int r = 0; r < 32; r++) run_op(r);

        repeat (20) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(int'($urandom_range(0, 31)));
        end

        for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/square_from_root.md
SQUARE_FROM_ROOT -- requirements
Module: square_from_root

Interface
REQ-001 The block SHALL have parameter ROOT_W, default 5, giving the root width in bits; the square width SQ_W SHALL be 2*ROOT_W (default 10).
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-004 Port start SHALL be an input, 1 bit wide: request pulse, sampled only in IDLE.
REQ-005 Port root SHALL be an input, ROOT_W bits wide: unsigned operand, captured on the accepting edge.
REQ-006 Port busy SHALL be an output, 1 bit wide: high while in CALC.
REQ-007 Port done SHALL be an output, 1 bit wide: one-cycle pulse, high while in DONE.
REQ-008 Port square SHALL be an output, SQ_W bits wide: root*root, i.e. the smallest num whose floor square root equals root.
REQ-009 Port square_hi SHALL be an output, SQ_W bits wide, and SHALL exist only with SQUARE_HI_EN: root*root + 2*root, i.e. the largest num whose floor square root equals root.

Function
REQ-010 The FSM SHALL have states IDLE, CALC and DONE.
REQ-011 In IDLE with start=1, the block SHALL, at that edge (E0): capture root into a multiplicand register and a multiplier shift register; clear the accumulator; set bit count to 0; enter CALC.
REQ-012 In CALC, each edge SHALL add (multiplicand << count) to the accumulator if the multiplier LSB is 1, shift the multiplier right by 1, and increment count.
REQ-013 The block SHALL process exactly ROOT_W bits in ROOT_W CALC cycles (edges E1..E5 at default).
REQ-014 On the final CALC edge (E5), square SHALL load the final sum, the FSM SHALL enter DONE, and done SHALL be 1.
REQ-015 On the next edge (E6), the FSM SHALL return from DONE to IDLE and done SHALL return to 0.
REQ-016 Latency from the start-sampling edge to done high SHALL be ROOT_W edges, with the next start accepted at the edge after DONE at the earliest.
REQ-017 start SHALL be ignored in CALC and DONE, with no queueing; root changes after E0 SHALL have no effect.
REQ-018 square (and square_hi) SHALL hold their last result until the next completion, and SHALL not change during CALC.
REQ-019 The accumulator SHALL be SQ_W bits wide and SHALL never overflow, because (2^ROOT_W-1)^2 < 2^SQ_W.
REQ-020 root=0 SHALL still take the full ROOT_W cycles and yield 0.

Reset
REQ-021 With rst=1 at an edge, the block SHALL force IDLE and set busy=0, done=0, square=0, square_hi=0, and clear the accumulator and count.
REQ-022 rst SHALL override start at the same edge.
REQ-023 rst during CALC or DONE SHALL abort the operation, produce no done pulse, and leave the block ready for start on the edge after rst deasserts.

Configuration
REQ-024 With macro SQUARE_HI_EN defined, the block SHALL provide port square_hi, loaded at the same edge as square with square + (multiplicand << 1), computed in SQ_W bits with no overflow (maximum 2^SQ_W-1).
REQ-025 With SQUARE_HI_EN undefined, port square_hi and its adder SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package square_pkg SHALL hold the ROOT_W default, the SQ_W derivation and the FSM state enum (IDLE, CALC, DONE).
REQ-027 There SHALL be no sub-module; the shift-add datapath and FSM SHALL live in one module.

Verification
REQ-028 The bench SHALL apply root=12 with a start pulse and check: busy for 5 cycles; done at E5; square=144; square_hi=168 (if enabled).
REQ-029 The bench SHALL apply root=31 and check square=961 and square_hi=1023; then apply root=0 and check square=0, square_hi=0, done still at E5.
REQ-030 The bench SHALL apply root=5, then pulse start with root=9 at E2, and check: second start ignored; square=25; no second done.
REQ-031 The bench SHALL apply root=20, assert rst at E3, then deassert, and check: no done; square=0; busy=0; then root=3 gives square=9 after 5 cycles.
REQ-032 The bench SHALL issue back-to-back requests (7, then start held high) and check: square=49, then the second accept at the edge after DONE; square=49 held until the next done.
REQ-033 The bench SHALL sweep exhaustively roots 0..31 and check that square equals root^2 for every root.
